// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional build macro: LSU_TIMEOUT_EN (adds a bounded wait on the memory side).
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        RESP
    } lsu_state_e;

    localparam int TIMEOUT_W = 8;
    localparam int LANES     = 4;

    // Byte-lane write strobes for an aligned access; illegal sizes get no lanes.
    function automatic logic [3:0] strobe_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] s;
        s = 4'b0000;
        case (size)
            SZ_B:    s = 4'b0001 << addr_lo;
            SZ_H:    s = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_W:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the
// returned word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  lanes [LANES];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane; word loads pass straight through.
    always_comb begin
        data = rdata;
        case (size)
            SZ_B:    data = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_H:    data = {{16{~uns & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request from execute becomes one word-aligned,
// byte-strobed memory transaction; loads are aligned and extended.
// Optional build macro: LSU_TIMEOUT_EN aborts after TIMEOUT cycles of waiting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_reg, state_next;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [1:0]        addr_lo_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_wstrb_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_data;
    logic              req_bad;
    logic              timeout_hit;

    // Illegal size or an address not aligned to the access size.
    assign req_bad = (req_size == 2'b11)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

    // Replicate store data across all lanes so the strobes alone pick the bytes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_wrep
            assign wdata_rep[8*gi +: 8] = (req_size == SZ_B) ? req_wdata[7:0] :
                                          (req_size == SZ_H) ? req_wdata[8*(gi%2) +: 8] :
                                                               req_wdata[8*gi +: 8];
        end
    endgenerate

`ifdef LSU_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);
    logic [TIMEOUT_W-1:0] cnt_reg;

    // Cycle counter for the memory-wait states, restarted on each entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if ((state_next != state_reg) && (state_next == ISSUE || state_next == WAIT_R)) begin
            cnt_reg <= '0;
        end else if (state_reg == ISSUE || state_reg == WAIT_R) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ISSUE || state_reg == WAIT_R) && (cnt_reg == TIMEOUT_CNT);
`else
    // No counter: the memory side may stall indefinitely.
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_bad ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_valid = ~timeout_hit;
                if (timeout_hit)    state_next = RESP;
                else if (mem_ready) state_next = mem_we_reg ? RESP : WAIT_R;
            end
            WAIT_R: begin
                if (timeout_hit || mem_rvalid) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory-side registers and response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_reg      <= 2'b00;
            uns_reg       <= 1'b0;
            addr_lo_reg   <= 2'b00;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wstrb_reg <= 4'b0000;
            mem_wdata_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (req_valid) begin
                    size_reg      <= req_size;
                    uns_reg       <= req_unsigned;
                    addr_lo_reg   <= req_addr[1:0];
                    mem_we_reg    <= req_we;
                    mem_addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb_reg <= req_we ? strobe_gen(req_size, req_addr[1:0]) : 4'b0000;
                    mem_wdata_reg <= wdata_rep;
                    rsp_rdata_reg <= '0;
                    rsp_err_reg   <= req_bad;
                end
                ISSUE: if (timeout_hit) rsp_err_reg <= 1'b1;
                WAIT_R: begin
                    if (timeout_hit) begin
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else if (mem_rvalid) begin
                        rsp_rdata_reg <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_reg),
        .size    (size_reg),
        .uns     (uns_reg),
        .data    (load_data)
    );

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests with expected
// memory-side and response values, a behavioural memory responder, and
// hand-written stall / reset sequences.
module tb_load_store_unit;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } mexp_t;
    typedef struct { logic [31:0] rdata; logic err; } rexp_t;

    vec_t  vecs[$];
    mexp_t mem_q[$];
    rexp_t rsp_q[$];
    logic [31:0] mem_model [0:63];

    int tests = 0;
    int fails = 0;

    int ready_delay  = 0;
    int rvalid_delay = 0;
    bit in_txn = 0;
    int wcnt = 0;
    bit rv_pending = 0;
    int rv_cnt = 0;
    logic [31:0] rv_data;
    mexp_t snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] maddr, input logic [3:0] wstrb,
                                input logic [31:0] mwdata, input logic [31:0] rdata,
                                input logic err, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_maddr = maddr; v.exp_wstrb = wstrb; v.exp_wdata = mwdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Memory responder: stalls mem_ready, checks the request, returns read data.
    always @(negedge clk) begin
        if (mem_rvalid) mem_rvalid = 1'b0;
        if (rv_pending) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rv_data;
                rv_pending = 0;
            end else begin
                rv_cnt--;
            end
        end
        mem_ready = 1'b0;
        if (rst === 1'b1 && mem_valid === 1'b1) begin
            if (!in_txn) begin
                in_txn = 1;
                wcnt = 0;
                snap.we = mem_we; snap.addr = mem_addr; snap.wstrb = mem_wstrb; snap.wdata = mem_wdata;
                if (mem_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_mem_valid: got addr 0x%08h required no request", mem_addr);
                end
            end else begin
                check("mem_stable", {31'd0, (snap.we === mem_we && snap.addr === mem_addr &&
                                             snap.wstrb === mem_wstrb && snap.wdata === mem_wdata)}, 32'd1);
            end
            if (wcnt >= ready_delay) begin
                mem_ready = 1'b1;
                in_txn = 0;
                if (mem_q.size() != 0) begin
                    mexp_t e;
                    e = mem_q.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem_model[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    rv_pending = 1;
                    rv_cnt = rvalid_delay;
                    rv_data = mem_model[mem_addr[7:2]];
                end
            end else begin
                wcnt++;
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_rsp_valid: got rdata 0x%08h required no response", rsp_rdata);
            end else begin
                rexp_t r;
                r = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, r.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            end
        end
    end

    task automatic issue_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bit acc = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got req_ready low required high");
        end
    endtask

    task automatic wait_rsp(input int exp_lat, input int bound, output int lat);
        bit seen = 0;
        lat = 0;
        for (int k = 1; k <= bound && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; lat = k; end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: got no rsp_valid required one within %0d cycles", bound);
        end else if (exp_lat != 0) begin
            check("latency", lat, exp_lat);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rexp_t r;
        mexp_t m;
        int lat;
        r.rdata = v.exp_rdata; r.err = v.exp_err;
        rsp_q.push_back(r);
        if (!v.exp_err) begin
            m.we = v.we; m.addr = v.exp_maddr; m.wstrb = v.exp_wstrb; m.wdata = v.exp_wdata;
            mem_q.push_back(m);
        end
        issue_req(v.we, v.size, v.uns, v.addr, v.wdata);
        wait_rsp(v.exp_lat, 600, lat);
        $display("[TB] txn %0d we=%0d size=%0d uns=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
                 idx, v.we, v.size, v.uns, v.addr, rsp_rdata, rsp_err, lat);
        @(posedge clk);
    endtask

    task automatic flush();
        mem_q.delete();
        rsp_q.delete();
        in_txn = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rexp_t r;
        mexp_t m;

        for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;
        mem_model[4] = 32'h80FF_7F01;

        // Expected results written out by hand from the access rules.
        vecs.push_back(mk(1, W, 0, 32'h40, 32'h1234_5678, 32'h40, 4'b1111, 32'h1234_5678, 32'h0, 0, 2));
        vecs.push_back(mk(0, W, 0, 32'h40, 32'h0, 32'h40, 4'b0000, 32'h0, 32'h1234_5678, 0, 3));
        vecs.push_back(mk(0, W, 0, 32'h10, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h80FF_7F01, 0, 3));
        vecs.push_back(mk(0, B, 0, 32'h13, 32'h0, 32'h10, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 3));
        vecs.push_back(mk(0, B, 1, 32'h13, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h0000_0080, 0, 3));
        vecs.push_back(mk(0, H, 0, 32'h10, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h0000_7F01, 0, 3));
        vecs.push_back(mk(0, H, 0, 32'h12, 32'h0, 32'h10, 4'b0000, 32'h0, 32'hFFFF_80FF, 0, 3));
        vecs.push_back(mk(0, B, 1, 32'h10, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h0000_0001, 0, 3));
        vecs.push_back(mk(0, B, 0, 32'h11, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h0000_007F, 0, 3));
        vecs.push_back(mk(0, H, 1, 32'h12, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h0000_80FF, 0, 3));
        vecs.push_back(mk(1, H, 0, 32'h22, 32'h1234_ABCD, 32'h20, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 2));
        vecs.push_back(mk(1, B, 0, 32'h21, 32'hFFFF_FF5A, 32'h20, 4'b0010, 32'h5A5A_5A5A, 32'h0, 0, 2));
        vecs.push_back(mk(0, W, 0, 32'h20, 32'h0, 32'h20, 4'b0000, 32'h0, 32'hABCD_5A00, 0, 3));
        vecs.push_back(mk(0, B, 0, 32'h21, 32'h0, 32'h20, 4'b0000, 32'h0, 32'h0000_005A, 0, 3));
        vecs.push_back(mk(0, H, 0, 32'h22, 32'h0, 32'h20, 4'b0000, 32'h0, 32'hFFFF_ABCD, 0, 3));
        vecs.push_back(mk(0, H, 1, 32'h22, 32'h0, 32'h20, 4'b0000, 32'h0, 32'h0000_ABCD, 0, 3));
        vecs.push_back(mk(1, B, 0, 32'h20, 32'h0000_0077, 32'h20, 4'b0001, 32'h7777_7777, 32'h0, 0, 2));
        vecs.push_back(mk(1, B, 0, 32'h23, 32'h0000_0099, 32'h20, 4'b1000, 32'h9999_9999, 32'h0, 0, 2));
        vecs.push_back(mk(1, H, 0, 32'h30, 32'h0000_BEEF, 32'h30, 4'b0011, 32'hBEEF_BEEF, 32'h0, 0, 2));
        vecs.push_back(mk(0, W, 0, 32'h20, 32'h0, 32'h20, 4'b0000, 32'h0, 32'h99CD_5A77, 0, 3));
        vecs.push_back(mk(0, W, 0, 32'h30, 32'h0, 32'h30, 4'b0000, 32'h0, 32'h0000_BEEF, 0, 3));
        vecs.push_back(mk(0, W, 0, 32'h05, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(1, H, 0, 32'h03, 32'hFFFF, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(0, X, 0, 32'h40, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(0, H, 1, 32'h11, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(1, W, 0, 32'h42, 32'h1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1));

        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        rst = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Stalled handshake and delayed read data.
        ready_delay = 3; rvalid_delay = 4;
        run_vec(100, mk(0, W, 0, 32'h10, 32'h0, 32'h10, 4'b0000, 32'h0, 32'h80FF_7F01, 0, 0));
        run_vec(101, mk(1, B, 0, 32'h12, 32'h0000_00C3, 32'h10, 4'b0100, 32'hC3C3_C3C3, 32'h0, 0, 0));
        run_vec(102, mk(0, B, 0, 32'h12, 32'h0, 32'h10, 4'b0000, 32'h0, 32'hFFFF_FFC3, 0, 0));
        ready_delay = 0; rvalid_delay = 0;

        // Reset while the request is being offered: mem_valid must drop at once.
        ready_delay = 100;
        r.rdata = 0; r.err = 0; rsp_q.push_back(r);
        m.we = 1; m.addr = 32'h40; m.wstrb = 4'b1111; m.wdata = 32'h0; mem_q.push_back(m);
        issue_req(1, W, 0, 32'h40, 32'h0);
        @(negedge clk);
        check("issue_mem_valid", {31'd0, mem_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_issue_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_issue_req_ready", {31'd0, req_ready}, 32'd1);
        flush();
        @(negedge clk); rst = 1'b1;
        ready_delay = 0;
        $display("[TB] txn reset-in-ISSUE done");

        // Reset while waiting for read data; the late rvalid must be ignored.
        rvalid_delay = 8;
        r.rdata = 32'h1234_5678; r.err = 0; rsp_q.push_back(r);
        m.we = 0; m.addr = 32'h40; m.wstrb = 4'b0000; m.wdata = 32'h0; mem_q.push_back(m);
        issue_req(0, W, 0, 32'h40, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_waitr_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_waitr_req_ready", {31'd0, req_ready}, 32'd1);
        flush();
        @(negedge clk); rst = 1'b1;
        lat = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        check("rst_waitr_no_rsp", lat, 32'd0);
        check("rst_waitr_idle", {31'd0, req_ready}, 32'd1);
        rvalid_delay = 0;
        $display("[TB] txn reset-in-WAIT_R done");

        // The unit must still work normally afterwards.
        run_vec(200, mk(0, W, 0, 32'h40, 32'h0, 32'h40, 4'b0000, 32'h0, 32'h1234_5678, 0, 3));

`ifdef LSU_TIMEOUT_EN
        // Memory never accepts: the unit aborts with an error.
        ready_delay = 1000000;
        r.rdata = 32'h0; r.err = 1; rsp_q.push_back(r);
        m.we = 0; m.addr = 32'h40; m.wstrb = 4'b0000; m.wdata = 32'h0; mem_q.push_back(m);
        issue_req(0, W, 0, 32'h40, 32'h0);
        wait_rsp(0, 400, lat);
        check("timeout_latency_window", {31'd0, (lat >= 255 && lat <= 258)}, 32'd1);
        $display("[TB] txn timeout lat=%0d err=%0d", lat, rsp_err);
        @(posedge clk);
        flush();
        ready_delay = 0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_rsp_drained", rsp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory interface. Accepts one load or store per request from the execute stage and issues one word-aligned, byte-strobed transaction to the data memory responder.
- On loads it aligns and sign- or zero-extends the returned lane. It flags misaligned or illegal accesses without touching memory.
- Sits between the execute stage and the data memory, replacing the direct combinational address/WE/WD hookup.

Parameters:
- ADDR_W, 32, byte-address width for the request and the memory.
- DATA_W, 32, data width; fixed at 32, giving 4 byte lanes.
- TIMEOUT, 255, maximum cycles spent waiting in ISSUE or WAIT_R before abort (LSU_TIMEOUT_EN only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  zero-extend the load result (lbu/lhu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or timeout; qualified by rsp_valid
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0
- mem_wstrb  out  4  byte write strobes; 0000 on loads
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data word

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0; timeout counter 0.
- FSM has four states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: a request is accepted when req_valid is high. All request fields are registered.
  - Misaligned or illegal request (half with addr[0]=1, word with addr[1:0]!=0, or size 11): go to RESP with err=1. No mem_valid is ever raised.
  - Otherwise go to ISSUE.
- ISSUE: mem_valid=1. mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until mem_ready is sampled high.
  - On handshake, a store goes to RESP with err=0; a load goes to WAIT_R.
  - mem_valid drops the cycle after the handshake.
- WAIT_R: wait for mem_rvalid. mem_rvalid sampled in ISSUE is ignored, so the earliest load data arrives the cycle after the handshake. On mem_rvalid, capture the extended lane and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Latency with zero-wait memory: store accepts at cycle 0 and responds at cycle 2; load with rvalid one cycle after handshake responds at cycle 3; error responds at cycle 1.
- Strobes and write data by size:
  - byte: wstrb = 0001<<addr[1:0]; wdata = wdata[7:0] replicated x4.
  - half: wstrb = 0011<<{addr[1],1'b0}; wdata = wdata[15:0] replicated x2.
  - word: wstrb = 1111; wdata passes through.
- Load extraction: select the lane using addr[1:0]. Sign-extend from bit 7 or bit 15 unless req_unsigned is set; word loads pass through unchanged.
- Reset mid-operation: asynchronous return to IDLE with mem_valid low immediately. Any in-flight response is dropped and late mem_rvalid is ignored.
- req_valid outside IDLE is ignored; the core must hold the request until req_ready is high.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to ISSUE or WAIT_R and increments each cycle spent in those states. When it reaches TIMEOUT, the FSM forces mem_valid low and goes to RESP with err=1, rsp_rdata=0.
- Undefined: no counter is built, and the FSM waits indefinitely in ISSUE and WAIT_R.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W)
  - state enum (IDLE, ISSUE, WAIT_R, RESP)
  - localparam TIMEOUT_W=8
  - function strobe_gen(size, addr_lo)
- One sub-module, lsu_load_align: combinational lane select and sign/zero extension taking rdata, addr[1:0], size and unsigned as inputs.

Test Plan:
- sw 0x1234_5678 to 0x40, then lw 0x40 → mem_addr=0x40, wstrb=1111, then rsp_rdata=0x1234_5678, err=0.
- mem word 0x80FF_7F01 at 0x10: lb 0x13 → 0xFFFF_FF80; lbu 0x13 → 0x0000_0080; lh 0x10 → 0x0000_7F01; lh 0x12 → 0xFFFF_80FF.
- sh 0xABCD to 0x22 → mem_addr=0x20, wstrb=1100, wdata=0xABCD_ABCD; sb 0x5A to 0x21 → wstrb=0010, wdata=0x5A5A_5A5A.
- lw 0x05, sh 0x03, and size=11 → mem_valid never high; rsp_valid one cycle after accept with err=1.
- mem_ready held low 3 cycles, then rvalid delayed 4 cycles → outputs stable throughout; exactly one rsp_valid pulse. With LSU_TIMEOUT_EN and mem_ready tied low → err=1 after 255 cycles.
- rst asserted while in WAIT_R, then mem_rvalid arrives → no rsp_valid, req_ready=1, mem_valid=0 immediately.
